tracker_query_arbiter: RTL and testbench

- Shares one signal_tracker query port between NUM_REQ requesters (e.g. trace encoder, memory-timing checker, debug readout).
- Arbitrates round-robin and latches the winner's operands onto the tracker's operand inputs.
- Generates the tracker's rising-edge recalculate strobes with a guaranteed setup cycle, waits a settle window, then captures the result.
- Returns the captured result to the winner over a valid/ready handshake.

---
 rtl/tracker_query_arbiter.sv | 148 ++++++++++++++
 tb/tb_tracker_query_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tracker_query_arbiter.sv
// tracker_query_arbiter: round-robin sharing of one signal_tracker query port with setup/strobe/settle sequencing
module tracker_query_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [2*NUM_REQ-1:0]  op_i,
   input  logic [32*NUM_REQ-1:0] arg0_i,
   input  logic [32*NUM_REQ-1:0] arg1_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   input  logic [NUM_REQ-1:0]    rsp_ready_i,
   output logic [63:0]           rsp_data_o,
   output logic                  busy_o,
   output logic [31:0]           value_o,
   output logic [31:0]           range_lo_o,
   output logic [31:0]           range_hi_o,
   output logic [31:0]           cycles_back_o,
   output logic                  recalc_time_o,
   output logic                  recalc_range_o,
   output logic                  recalc_single_o,
   output logic                  recalc_back_o,
   input  logic [63:0]           time_i,
   input  logic                  range_i,
   input  logic [31:0]           single_i,
   input  logic                  recall_i
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, CAPTURE, RESPOND} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, sel;
   logic          found;
   logic [1:0]    op_q, op_d, op_sel;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    stb_q, stb_d;
   logic [31:0]   value_q, value_d, lo_q, lo_d, hi_q, hi_d, cb_q, cb_d, a0_sel, a1_sel;
   logic [63:0]   data_q, data_d;
   logic [NUM_REQ-1:0] gnt;

   // first requester at or after the pointer, circular
   always_comb begin
      int idx;
      idx = 0;
      sel = ptr_q;
      found = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_i[idx]) begin
            sel = IW'(idx);
            found = 1'b1;
         end
      end
   end

   assign op_sel = op_i[2*sel +: 2];
   assign a0_sel = arg0_i[32*sel +: 32];
   assign a1_sel = arg1_i[32*sel +: 32];

   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      win_d = win_q;
      op_d = op_q;
      cnt_d = cnt_q;
      stb_d = '0;
      value_d = value_q;
      lo_d = lo_q;
      hi_d = hi_q;
      cb_d = cb_q;
      data_d = data_q;
      gnt = '0;
      case (state_q)
         IDLE: if (found) begin
            gnt[sel] = 1'b1;
            win_d = sel;
            op_d = op_sel;
            ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            value_d = (op_sel == 2'd0) ? a0_sel : value_q;
            lo_d = (op_sel == 2'd1 || op_sel == 2'd2) ? a0_sel : lo_q;
            hi_d = (op_sel == 2'd1 || op_sel == 2'd2) ? a1_sel : hi_q;
            cb_d = (op_sel == 2'd3) ? a0_sel : cb_q;
            state_d = SETUP;
         end
         SETUP: begin
            stb_d[op_q] = 1'b1;
            state_d = STROBE;
         end
         STROBE: begin
            cnt_d = CW'(SETTLE_CYCLES - 1);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? CAPTURE : WAIT;
         end
         CAPTURE: begin
            data_d = (op_q == 2'd0) ? time_i :
                     (op_q == 2'd1) ? {63'd0, range_i} :
                     (op_q == 2'd2) ? {{32{single_i[31]}}, single_i} : {63'd0, recall_i};
            state_d = RESPOND;
         end
         RESPOND: state_d = rsp_ready_i[win_q] ? IDLE : RESPOND;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         win_q <= '0;
         op_q <= '0;
         cnt_q <= '0;
         stb_q <= '0;
         value_q <= '0;
         lo_q <= '0;
         hi_q <= '0;
         cb_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         op_q <= op_d;
         cnt_q <= cnt_d;
         stb_q <= stb_d;
         value_q <= value_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
         cb_q <= cb_d;
         data_q <= data_d;
      end
   end

   assign gnt_o = rst ? '0 : gnt;
   assign rsp_valid_o = (state_q == RESPOND) ? (NUM_REQ'(1) << win_q) : '0;
   assign rsp_data_o = data_q;
   assign busy_o = state_q != IDLE;
   assign value_o = value_q;
   assign range_lo_o = lo_q;
   assign range_hi_o = hi_q;
   assign cycles_back_o = cb_q;
   assign {recalc_back_o, recalc_single_o, recalc_range_o, recalc_time_o} = stb_q;
endmodule

// File: tb/tb_tracker_query_arbiter.sv
// tb_tracker_query_arbiter: directed and random queries checked against a transaction-level model
module tb_tracker_query_arbiter;
   localparam int S1 = 1;
   logic clk, rst;
   logic [3:0] req, rdy, req3, rdy3;
   logic [7:0] op;
   logic [127:0] a0, a1;
   logic [63:0] tm;
   logic rng, rec;
   logic [31:0] sgl;
   logic [3:0] gnt, vld, gnt3, vld3;
   logic [63:0] data, data3;
   logic busy, busy3, rt, rr, rs, rb, rt3, rr3, rs3, rb3;
   logic [31:0] value, lo, hi, cb, value3, lo3, hi3, cb3;
   int total = 0, bad = 0;
   int ptr_m = 0;
   logic [31:0] value_m = 0, lo_m = 0, hi_m = 0, cb_m = 0;

   tracker_query_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(S1)) dut (
      .clk(clk), .rst(rst), .req_i(req), .op_i(op), .arg0_i(a0), .arg1_i(a1),
      .gnt_o(gnt), .rsp_valid_o(vld), .rsp_ready_i(rdy), .rsp_data_o(data), .busy_o(busy),
      .value_o(value), .range_lo_o(lo), .range_hi_o(hi), .cycles_back_o(cb),
      .recalc_time_o(rt), .recalc_range_o(rr), .recalc_single_o(rs), .recalc_back_o(rb),
      .time_i(tm), .range_i(rng), .single_i(sgl), .recall_i(rec));

   tracker_query_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .req_i(req3), .op_i(op), .arg0_i(a0), .arg1_i(a1),
      .gnt_o(gnt3), .rsp_valid_o(vld3), .rsp_ready_i(rdy3), .rsp_data_o(data3), .busy_o(busy3),
      .value_o(value3), .range_lo_o(lo3), .range_hi_o(hi3), .cycles_back_o(cb3),
      .recalc_time_o(rt3), .recalc_range_o(rr3), .recalc_single_o(rs3), .recalc_back_o(rb3),
      .time_i(tm), .range_i(rng), .single_i(sgl), .recall_i(rec));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one query on the main instance; tracker inputs are taken from tm/rng/sgl/rec as set by the caller
   task automatic txn(input logic [3:0] rq, input logic [7:0] ops, input logic [127:0] x0,
                      input logic [127:0] x1, input int dly, input logic [3:0] orr);
      int w;
      logic [1:0] o;
      logic [3:0] wm;
      logic [63:0] ed;
      longint s;
      @(negedge clk);
      req = rq; op = ops; a0 = x0; a1 = x1; rdy = orr;
      #1;
      chk("idle_busy", busy, 0);
      w = -1;
      for (int k = 3; k >= 0; k--) if (rq[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      if (w < 0) begin
         chk("no_gnt", gnt, 0);
         return;
      end
      wm = 4'(1 << w);
      chk("gnt", gnt, wm);
      o = ops[2*w +: 2];
      case (o)
         2'd0: value_m = x0[32*w +: 32];
         2'd3: cb_m = x0[32*w +: 32];
         default: begin lo_m = x0[32*w +: 32]; hi_m = x1[32*w +: 32]; end
      endcase
      ptr_m = (w + 1) % 4;
      s = $signed(sgl);
      ed = (o == 2'd0) ? tm : (o == 2'd1) ? 64'(rng) : (o == 2'd2) ? s : 64'(rec);
      for (int c = 1; c <= 3 + S1; c++) begin
         @(negedge clk);
         req = 4'($urandom); op = 8'($urandom); a0 = {$urandom, $urandom, $urandom, $urandom};
         a1 = {$urandom, $urandom, $urandom, $urandom}; rdy = orr & ~wm;
         #1;
         chk("busy", busy, 1);
         chk("gnt_busy", gnt, 0);
         chk("strobe", {rb, rs, rr, rt}, (c == 2) ? 4'(1 << o) : 4'b0);
         chk("vld_early", vld, 0);
         chk("value", value, value_m);
         chk("range_lo", lo, lo_m);
         chk("range_hi", hi, hi_m);
         chk("cycles_back", cb, cb_m);
      end
      for (int d = 0; d <= dly; d++) begin
         @(negedge clk);
         req = 4'($urandom); op = 8'($urandom);
         rdy = (orr & ~wm) | ((d == dly) ? wm : 4'b0);
         #1;
         chk("rsp_busy", busy, 1);
         chk("rsp_gnt", gnt, 0);
         chk("rsp_strobe", {rb, rs, rr, rt}, 0);
         chk("rsp_valid", vld, wm);
         chk("rsp_data", data, ed);
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; rdy = '0; req3 = '0; rdy3 = '0; op = '0; a0 = '0; a1 = '0;
      tm = '0; rng = 1'b0; sgl = '0; rec = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_outputs", {gnt, vld, busy, rt, rr, rs, rb}, 0);
      chk("rst_operands", {value, lo, hi, cb}, 0);
      chk("rst_data", data, 0);
      // single TIME query
      tm = {32'd12, 32'd10};
      txn(4'b0001, 8'h00, 128'd3, 128'd0, 0, 4'b0000);
      // RANGE from requester 2 under backpressure
      rng = 1'b1;
      txn(4'b0100, 8'h10, 128'd7 << 64, 128'd9 << 64, 5, 4'b1011);
      // RECALL, value_o must keep the TIME operand
      rec = 1'b1;
      txn(4'b1000, 8'hC0, 128'd2 << 96, 128'd0, 0, 4'b0000);
      // reset while the single-cycle strobe is high
      @(negedge clk);
      req = 4'b0010; op = 8'h08; a0 = 128'd5 << 32; a1 = 128'd6 << 32;
      #1;
      chk("mid_gnt", gnt, 4'b0010);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      #1;
      chk("mid_strobe", rs, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_outputs", {gnt, vld, busy, rt, rr, rs, rb}, 0);
      chk("mid_rst_operands", {value, lo, hi, cb}, 0);
      ptr_m = 0; value_m = 0; lo_m = 0; hi_m = 0; cb_m = 0;
      // round robin with all requesters active, including the wrap
      for (int i = 0; i < 5; i++) txn(4'b1111, 8'h00, 128'd0, 128'd0, 0, 4'b1111);
      // long settle window instance
      @(negedge clk);
      req = '0; req3 = 4'b0010; op = 8'h08; a0 = 128'd4 << 32; a1 = 128'd8 << 32; sgl = 32'hFFFF_FFFF; rdy3 = '0;
      #1;
      chk("s3_gnt", gnt3, 4'b0010);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         req3 = '0;
         #1;
         chk("s3_busy", busy3, 1);
         chk("s3_vld", vld3, 0);
         chk("s3_strobe", {rb3, rs3, rr3, rt3}, (c == 2) ? 4'b0100 : 4'b0000);
         if (c == 1) chk("s3_range", {hi3, lo3}, {32'd8, 32'd4});
      end
      @(negedge clk);
      rdy3 = 4'b0010;
      #1;
      chk("s3_rsp_valid", vld3, 4'b0010);
      chk("s3_rsp_data", data3, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      rdy3 = '0;
      #1;
      chk("s3_done", {busy3, vld3}, 0);
      // random queries
      for (int i = 0; i < 40; i++) begin
         tm = {$urandom, $urandom}; rng = 1'($urandom); sgl = $urandom; rec = 1'($urandom);
         txn(4'($urandom), 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 4'($urandom));
      end
      @(negedge clk);
      req = '0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
